// File: rtl/alu_seq.sv
// Multi-cycle LEGv8 ALU: single-cycle logic/arith ops with NZCV flags and an
// iterative shift-add unsigned multiply, valid/ready on both input and output.
`timescale 1ns/1ps

module alu_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUcontrol,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         illegal
);

    localparam int CNT_W = $clog2(N + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     result_q, result_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // SUB is a + ~b + 1 so bit N is the inverted borrow (a >= b unsigned).
    logic [N:0] add_sum, sub_sum;
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    logic [N-1:0] alu_res;
    logic         alu_c, alu_v, alu_ill;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (ALUcontrol)
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_ADD: begin
                alu_res = add_sum[N-1:0];
                alu_c   = add_sum[N];
                alu_v   = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res = sub_sum[N-1:0];
                alu_c   = sub_sum[N];
                alu_v   = (a[N-1] != b[N-1]) && (sub_sum[N-1] != a[N-1]);
            end
            OP_PASSB: alu_res = b;
            OP_MUL:   alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    logic [2*N-1:0] acc_step;
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALUcontrol == OP_MUL) begin
                        mcand_d  = {{N{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(N);
                        state_d  = S_MUL;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        negative_d = alu_res[N-1];
                        carry_d    = alu_c;
                        overflow_d = alu_v;
                        illegal_d  = alu_ill;
                        state_d    = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // Last iteration: publish straight from the adder to keep latency at N+1.
                if (cnt_q == CNT_W'(1)) begin
                    result_d   = acc_step[N-1:0];
                    zero_d     = (acc_step[N-1:0] == '0);
                    negative_d = acc_step[N-1];
                    carry_d    = 1'b0;
                    overflow_d = |acc_step[2*N-1:N];
                    illegal_d  = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the multiply datapath registers are reset too, so a mid-MUL reset leaves no stale state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors with literal expectations plus a
// cycle-level reference model compared on every falling edge.
`timescale 1ns/1ps

module tb_alu_seq;

    localparam int N = 64;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   ALUcontrol = '0;
    logic         in_ready, out_valid;
    logic [N-1:0] result;
    logic         zero, negative, carry, overflow, illegal;
    logic [4:0]   fl_dut;

    assign fl_dut = {zero, negative, carry, overflow, illegal};

    alu_seq #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUcontrol(ALUcontrol),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  fl;   // {Z, N, C, V, illegal}
    } exp_t;

    // Reference: exact-width integer arithmetic, overflow judged by true signed value.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op);
        exp_t              e;
        logic [127:0]      p;
        logic signed [65:0] sx, sy, ss, rs;
        logic [63:0]       r;
        logic              c, v, ill;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        sx = $signed({{2{x[63]}}, x});
        sy = $signed({{2{y[63]}}, y});
        case (op)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_ADD: begin
                r  = x + y;
                p  = {64'd0, x} + {64'd0, y};
                c  = (p > 128'hFFFF_FFFF_FFFF_FFFF);
                ss = sx + sy;
                rs = $signed({{2{r[63]}}, r});
                v  = (ss != rs);
            end
            OP_SUB: begin
                r  = x - y;
                c  = (x >= y);
                ss = sx - sy;
                rs = $signed({{2{r[63]}}, r});
                v  = (ss != rs);
            end
            OP_PASSB: r = y;
            OP_MUL: begin
                p = {64'd0, x} * {64'd0, y};
                r = p[63:0];
                v = (p > 128'hFFFF_FFFF_FFFF_FFFF);
            end
            default: ill = 1'b1;
        endcase
        e.res = r;
        e.fl  = {(r == 64'd0), r[63], c, v, ill};
        return e;
    endfunction

    // Model timeline: accept in cycle k -> result valid from cycle k+latency until handshake.
    int   cyc;
    int   ready_cyc;
    logic pending;
    exp_t exp_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            cyc     <= 0;
        end else begin
            if (pending) begin
                if (cyc >= ready_cyc && out_ready) pending <= 1'b0;
            end else if (in_valid) begin
                pending   <= 1'b1;
                ready_cyc <= cyc + ((ALUcontrol == OP_MUL) ? N + 1 : 1);
                exp_q     <= model(a, b, ALUcontrol);
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cmp_in_ready", in_ready, !pending);
            check("cmp_out_valid", out_valid, pending && (cyc >= ready_cyc));
            if (pending && cyc >= ready_cyc) begin
                check("cmp_result", result, exp_q.res);
                check("cmp_flags", fl_dut, exp_q.fl);
            end
        end
    end

    task automatic check_reset_values(input string name);
        check({name, "_result"}, result, 64'd0);
        check({name, "_flags"}, fl_dut, 5'b00000);
        check({name, "_in_ready"}, in_ready, 1'b1);
        check({name, "_out_valid"}, out_valid, 1'b0);
    endtask

    // Called #1 after a rising edge with the unit idle. Inputs are kept busy with junk
    // after acceptance to show they are ignored until the output handshake completes.
    task automatic do_op(input string name, input logic [63:0] ta, input logic [63:0] tbv,
                         input logic [3:0] op, input int stall, input int elat,
                         input logic [63:0] er, input logic [4:0] ef);
        int   lat;
        logic busy_ready;
        a = ta; b = tbv; ALUcontrol = op; in_valid = 1'b1; out_ready = 1'b0;
        check({name, "_accept_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        a = ~ta; b = ta ^ tbv; ALUcontrol = OP_ADD;
        lat = 1;
        busy_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_busy_in_ready"}, busy_ready, 1'b0);
        check({name, "_result"}, result, er);
        check({name, "_flags"}, fl_dut, ef);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check({name, "_held_result"}, result, er);
            check({name, "_held_valid"}, out_valid, 1'b1);
            check({name, "_held_in_ready"}, in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1'b1);
        check({name, "_idle_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #20;
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        //     name        a                       b                       op        stall lat  result                  {Z N C V I}
        do_op("add_2_2",   64'd2,                  64'd2,                  OP_ADD,   0,    1,   64'd4,                  5'b00000);
        do_op("sub_2_2",   64'd2,                  64'd2,                  OP_SUB,   0,    1,   64'd0,                  5'b10100);
        do_op("or_1_0",    64'd1,                  64'd0,                  OP_OR,    0,    1,   64'd1,                  5'b00000);
        do_op("and_mask",  64'hF0F0,               64'hFF00,               OP_AND,   0,    1,   64'hF000,               5'b00000);
        do_op("add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 OP_ADD,   0,    1,   64'd0,                  5'b10100);
        do_op("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 OP_ADD,   0,    1,   64'h8000_0000_0000_0000, 5'b01010);
        do_op("sub_borrow", 64'd1,                 64'd2,                  OP_SUB,   0,    1,   64'hFFFF_FFFF_FFFF_FFFF, 5'b01000);
        do_op("sub_ovf",   64'h8000_0000_0000_0000, 64'd1,                 OP_SUB,   0,    1,   64'h7FFF_FFFF_FFFF_FFFF, 5'b00110);
        do_op("mul_3_5",   64'd3,                  64'd5,                  OP_MUL,   0,    65,  64'd15,                 5'b00000);
        do_op("mul_ovf",   64'h8000_0000_0000_0000, 64'd2,                 OP_MUL,   0,    65,  64'd0,                  5'b10010);
        do_op("mul_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_MUL, 2,    65,  64'd1,                  5'b00010);
        do_op("passb",     64'hFFF,                64'd1,                  OP_PASSB, 5,    1,   64'd1,                  5'b00000);
        do_op("illegal_f", 64'd7,                  64'd9,                  4'b1111,  0,    1,   64'd0,                  5'b10001);
        do_op("illegal_3", 64'd7,                  64'd9,                  4'b0011,  1,    1,   64'd0,                  5'b10001);

        // Abort a multiply partway through with an asynchronous reset.
        a = 64'd5; b = 64'd7; ALUcontrol = OP_MUL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_reset_values("mid_mul_reset");
        @(posedge clk); #1;
        check_reset_values("mid_mul_reset_hold");
        reset = 1'b1;
        @(posedge clk); #1;
        do_op("add_after_reset", 64'd1, 64'd0, OP_ADD, 0, 1, 64'd1, 5'b00000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
